// File: rtl/muldiv_if.sv
// Handshake and data bundle between the control/register-file side and the
// iterative multiply/divide unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             hi_write;
  logic             lo_write;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, data_a, data_b, hi_write, lo_write,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, data_a, data_b, hi_write, lo_write,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with its own HI/LO pair: one result bit
// per cycle on operand magnitudes, sign fix-up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               bzero_q, bzero_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   in_a_mag, in_b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_signed = ~bus.op[0];
  assign a_neg     = is_signed & bus.data_a[WIDTH-1];
  assign b_neg     = is_signed & bus.data_b[WIDTH-1];
  assign in_a_mag  = a_neg ? -bus.data_a : bus.data_a;
  assign in_b_mag  = b_neg ? -bus.data_b : bus.data_b;

  // Multiply: add the multiplicand into the upper half when the current LSB
  // is set, then shift the whole product right; carry lands in bit 2W-1.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (prod_q[0] ? {1'b0, a_mag_q} : '0);

  // Restoring divide: the WIDTH+1-bit partial remainder is the stored
  // remainder shifted left with the next dividend bit brought in.
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_mag_q};

  // Divide-by-zero keeps the raw all-ones quotient; the remainder fix-up
  // still restores the dividend so hi reads back data_a.
  assign prod_fix  = neg_q_q ? -prod_q : prod_q;
  assign quo_fix   = (neg_q_q && !bzero_q) ? -quo_q : quo_q;
  assign rem_fix   = neg_r_q ? -rem_q : rem_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case statement can infer a latch.
    state_d = state_q;
    op_d    = op_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    bzero_d = bzero_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          op_d    = bus.op;
          a_mag_d = in_a_mag;
          b_mag_d = in_b_mag;
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          bzero_d = (bus.data_b == '0);
          cnt_d   = '0;
          prod_d  = {{WIDTH{1'b0}}, in_b_mag};
          rem_d   = '0;
          quo_d   = in_a_mag;
        end else begin
          if (bus.hi_write) hi_d = bus.data_a;
          if (bus.lo_write) lo_d = bus.data_a;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!op_q[1]) begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end else begin
          rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      bzero_q <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      bzero_q <= bzero_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, write-ordering and
// reset sequences, plus random operations against a 64-bit arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int LAT = W + 1;  // edges after the start edge until done is seen

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           disturb;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; divide by zero gives all-ones
  // quotient and the dividend as remainder.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = ua * ub;
      2'b10: if (b == 0) r = {a, 32'hFFFF_FFFF};
             else r = {32'(sa % sb), 32'(sa / sb)};
      default: if (b == 0) r = {a, 32'hFFFF_FFFF};
               else r = {32'(ua % ub), 32'(ua / ub)};
    endcase
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb, input bit wr_at_start,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    logic [W-1:0] hi0, lo0;
    int edges;
    int bad;
    bit seen;
    @(negedge clk);
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start    = 1'b1;
    bus.op       = op;
    bus.data_a   = a;
    bus.data_b   = b;
    bus.hi_write = wr_at_start;
    bus.lo_write = wr_at_start;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
    check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    if (wr_at_start) begin
      check({tag, " hi_write_dropped"}, 64'(bus.hi), 64'(hi0));
      check({tag, " lo_write_dropped"}, 64'(bus.lo), 64'(lo0));
    end
    edges = 0;
    bad   = 0;
    seen  = 1'b0;
    while (!seen && edges < 100) begin
      if (disturb) begin
        bus.data_a   = $urandom;
        bus.data_b   = $urandom;
        bus.start    = (edges == 4);
        bus.hi_write = (edges == 4) || (edges == 20);
        bus.lo_write = (edges == 7);
      end
      @(posedge clk);
      #1;
      edges++;
      bus.start    = 1'b0;
      bus.hi_write = 1'b0;
      bus.lo_write = 1'b0;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy !== 1'b1 || bus.hi !== hi0 || bus.lo !== lo0) bad++;
    end
    check({tag, " latency"}, 64'(edges), 64'(LAT));
    check({tag, " busy_hold_during_run"}, 64'(bad), 64'd0);
    check({tag, " busy_low_with_done"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    @(posedge clk);
    #1;
    check({tag, " done_single_cycle"}, 64'(bus.done), 64'd0);
  endtask

  task automatic write_regs(input bit hw, input bit lw, input logic [W-1:0] d);
    @(negedge clk);
    bus.hi_write = hw;
    bus.lo_write = lw;
    bus.data_a   = d;
    @(posedge clk);
    #1;
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
  endtask

  initial begin
    logic [63:0]  r;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,          1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,          1'b1, 32'd2,         32'd14};
    vecs[4] = '{2'b11, 32'd100,       32'd0,          1'b0, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{2'b10, 32'd5,         32'd0,          1'b0, 32'd5,         32'hFFFF_FFFF};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000,  1'b0, 32'h4000_0000, 32'h0000_0000};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 2'b00;
    bus.data_a   = '0;
    bus.data_b   = '0;
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
    #12;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].disturb,
             1'b0, vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // MTHI / MTLO in IDLE, then start with both writes in the same cycle
    write_regs(1'b1, 1'b0, 32'h0000_1234);
    check("mthi hi", 64'(bus.hi), 64'h1234);
    check("mthi lo_kept", 64'(bus.lo), 64'h0);
    write_regs(1'b0, 1'b1, 32'h0000_5678);
    check("mtlo lo", 64'(bus.lo), 64'h5678);
    check("mtlo hi_kept", 64'(bus.hi), 64'h1234);
    write_regs(1'b1, 1'b1, 32'hABCD_0001);
    check("mthilo hi", 64'(bus.hi), 64'hABCD_0001);
    check("mthilo lo", 64'(bus.lo), 64'hABCD_0001);
    run_op("start_vs_write", 2'b01, 32'd6, 32'd7, 1'b0, 1'b1, 32'd0, 32'd42);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 3) == 0) rb = -rb;
      if (rb == 0) rb = 32'd1;
      r = model(rop, ra, rb);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, (i % 5) == 0, 1'b0,
             r[63:32], r[31:0]);
    end

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 2'b00;
    bus.data_a = 32'h1234_5678;
    bus.data_b = 32'h8765_4321;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("pre_reset busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("async_reset busy", 64'(bus.busy), 64'd0);
    check("async_reset done", 64'(bus.done), 64'd0);
    check("async_reset hi", 64'(bus.hi), 64'd0);
    check("async_reset lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("after_reset multu", 2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'd0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with its own HI/LO register pair.
- Consumes the two register-file read operands (data_a = rs, data_b = rt) for MULT, MULTU, DIV and DIVU.
- Its hi/lo outputs feed the MFHI/MFLO path back to register-file write data.
- Raises busy so the control unit can stall any MFHI/MFLO or new mult/div instruction until the result is ready.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  launch the operation selected by op; sampled on posedge clk
op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
data_a  input  WIDTH  rs operand: multiplicand or dividend
data_b  input  WIDTH  rt operand: multiplier or divisor
hi_write  input  1  MTHI: load hi from data_a
lo_write  input  1  MTLO: load lo from data_a
busy  output  1  operation in progress; stall request
done  output  1  one-cycle pulse: hi/lo just updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE.
  - hi = 0, lo = 0, busy = 0, done = 0.
  - Internal accumulators are cleared.
- States:
  - IDLE -> RUN on start.
  - RUN holds for WIDTH cycles, then goes to FIX.
  - FIX lasts one cycle, then returns to IDLE.
- IDLE, on a start edge:
  - Latches op.
  - Latches operand magnitudes: abs value for signed ops, raw value for unsigned ops.
  - Latches result-sign flags:
    - Product / quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign(a).
  - Clears the iteration counter.
  - busy = 1 from that edge.
- RUN: one iteration per cycle, counter 0..WIDTH-1.
  - Multiply: shift-add into a 2*WIDTH product register, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first; remainder register is WIDTH+1 bits.
- FIX (one cycle):
  - Applies two's-complement sign correction for signed ops.
  - Writes the result to hi/lo on the edge leaving FIX:
    - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
    - Divide: lo = quotient, hi = remainder.
  - busy drops and done = 1 for exactly the following cycle.
- Latency: start sampled at edge E0; busy high E0..E33; hi/lo valid and done high after E33 (WIDTH+2 edges).
- hi/lo hold their old values throughout RUN/FIX.
- Divide by zero: no trap; the natural restoring result stands.
  - DIVU: lo = all ones, hi = data_a.
  - DIV: same raw values, with no sign correction applied.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0; no exception.
- start while busy: ignored; the current operation continues unaffected.
- hi_write / lo_write:
  - In IDLE: load data_a on the clock edge; both asserted loads both.
  - While busy: ignored.
  - In the same cycle as start in IDLE: start wins and the writes are dropped.
- done is never asserted in the same cycle as busy.
- Operands are captured at start; later changes on data_a/data_b have no effect.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=5 -> busy for 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFF1; single-cycle done.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; data_a/data_b toggled during RUN must not change the result.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=100, b=7 -> lo=14, hi=2.
- Boundary divides:
  - DIVU, a=100, b=0 -> lo=0xFFFFFFFF, hi=0x64.
  - DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Write ordering:
  - hi_write=1 with data_a=0x1234 in IDLE -> hi=0x1234.
  - hi_write pulsed during RUN -> ignored; final hi is the operation result.
  - start pulsed again at cycle 5 -> ignored; completion still at E33.
- Reset asserted asynchronously at cycle 10 of a MULT -> immediately busy=0, done=0, hi=lo=0; a new MULTU 6*7 afterwards -> lo=42, hi=0 after 34 cycles.
